audio_stream_ctrl: RTL and testbench

//  Sequences the sound-out path from decoded command ops. Start ops (0x1f?? 22 kHz,
//  0x0f?? 44 kHz) arm playback. The block prefills a sample FIFO from the DMA side,

---
 rtl/audio_stream_ctrl.sv | 179 +++++++++++++++++
 tb/tb_audio_stream_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_stream_ctrl.sv
// Sound-out sequencer: decodes command ops, prefills a small sample FIFO from DMA,
// then hands one stereo sample per 22/44 kHz rate tick to the DAC serializer.
module audio_stream_ctrl #(
    parameter int CLK_DIV_44K = 256,
    parameter int FIFO_DEPTH  = 4,
    parameter int LOW_WATER   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] op,
    input  logic        op_valid,
    input  logic [31:0] sample_in,
    input  logic        sample_in_valid,
    output logic        sample_in_ready,
    output logic        dma_req,
    output logic [31:0] sample_out,
    output logic        sample_strobe,
    output logic        rate_22k,
    output logic        streaming,
    output logic        underrun,
    output logic        power_on
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int DIV_W = $clog2(CLK_DIV_44K);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV_44K - 1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]    CNT_LW   = CW'(LOW_WATER);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} state_t;

    state_t                         state_q, state_d;
    logic [FIFO_DEPTH-1:0][31:0]    mem_q, mem_d;
    logic [AW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [DIV_W-1:0]               div_q, div_d;
    logic                           phase_q, phase_d;
    logic [31:0]                    sample_out_q, sample_out_d;
    logic                           strobe_q, strobe_d;
    logic                           rate_22k_q, rate_22k_d;
    logic                           underrun_q, underrun_d;
    logic                           power_on_q, power_on_d;

    logic is_start22, is_start44, is_start, is_flush, is_eos;
    logic running, wrap, tick, push, pop, full;

    assign full            = (cnt_q == CNT_FULL);
    assign sample_in_ready = ((state_q == PRIME) || (state_q == STREAM)) && !full;
    assign dma_req         = ((state_q == PRIME) || (state_q == STREAM)) && (cnt_q < CNT_LW);
    assign sample_out      = sample_out_q;
    assign sample_strobe   = strobe_q;
    assign rate_22k        = rate_22k_q;
    assign streaming       = (state_q != IDLE);
    assign underrun        = underrun_q;
    assign power_on        = power_on_q;

    always_comb begin
        is_start22 = op_valid && (op[15:8] == 8'h1f);
        is_start44 = op_valid && (op[15:8] == 8'h0f);
        is_start   = is_start22 || is_start44;
        is_flush   = op_valid && (op[15:8] == 8'hff);
        is_eos     = op_valid && (op[15:8] == 8'hc7) && op[0];

        running = (state_q == STREAM) || (state_q == DRAIN);
        wrap    = running && (div_q == DIV_MAX);
        // At 22 kHz only every second wrap produces a tick.
        tick    = wrap && (!rate_22k_q || phase_q);
        push    = sample_in_valid && sample_in_ready;
        pop     = 1'b0;

        state_d      = state_q;
        mem_d        = mem_q;
        div_d        = running ? (wrap ? '0 : div_q + 1'b1) : div_q;
        phase_d      = wrap ? ~phase_q : phase_q;
        sample_out_d = sample_out_q;
        strobe_d     = 1'b0;
        rate_22k_d   = rate_22k_q;
        underrun_d   = underrun_q;
        power_on_d   = op_valid && (op == 16'hc5ef);

        case (state_q)
            IDLE: begin
                if (is_start) begin
                    state_d    = PRIME;
                    rate_22k_d = is_start22;
                    div_d      = '0;
                    phase_d    = 1'b0;
                    underrun_d = 1'b0;
                end
            end
            PRIME: begin
                if (cnt_q >= CNT_LW) begin
                    state_d = STREAM;
                    div_d   = '0;
                    phase_d = 1'b0;
                end
            end
            STREAM: begin
                if (tick) begin
                    strobe_d = 1'b1;
                    if (cnt_q != '0) begin
                        pop          = 1'b1;
                        sample_out_d = mem_q[rd_ptr_q];
                    end else begin
                        sample_out_d = '0;
                        underrun_d   = 1'b1;
                    end
                end
                if (is_eos && !is_start) state_d = DRAIN;
            end
            DRAIN: begin
                if (tick) begin
                    if (cnt_q != '0) begin
                        pop          = 1'b1;
                        strobe_d     = 1'b1;
                        sample_out_d = mem_q[rd_ptr_q];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A restart while active retimes the rate but keeps queued samples.
        if (is_start && (state_q != IDLE)) begin
            rate_22k_d = is_start22;
            div_d      = '0;
            phase_d    = 1'b0;
        end

        if (push) mem_d[wr_ptr_q] = sample_in;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);

        if (is_flush) begin
            state_d      = IDLE;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            cnt_d        = '0;
            sample_out_d = '0;
            strobe_d     = 1'b0;
            underrun_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mem_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            div_q        <= '0;
            phase_q      <= 1'b0;
            sample_out_q <= '0;
            strobe_q     <= 1'b0;
            rate_22k_q   <= 1'b0;
            underrun_q   <= 1'b0;
            power_on_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            phase_q      <= phase_d;
            sample_out_q <= sample_out_d;
            strobe_q     <= strobe_d;
            rate_22k_q   <= rate_22k_d;
            underrun_q   <= underrun_d;
            power_on_q   <= power_on_d;
        end
    end

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Directed bench for audio_stream_ctrl: prefill, both rates, underrun, full FIFO,
// end-of-stream drain, flush from every active state, power-on and async reset.
module tb_audio_stream_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] op = '0;
    logic        op_valid = 1'b0;
    logic [31:0] sample_in = '0;
    logic        sample_in_valid = 1'b0;
    logic        sample_in_ready, dma_req, sample_strobe, rate_22k, streaming, underrun, power_on;
    logic [31:0] sample_out;

    int checks = 0;
    int failures = 0;
    int n;
    logic seen;

    audio_stream_ctrl #(.CLK_DIV_44K(256), .FIFO_DEPTH(4), .LOW_WATER(2)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .op_valid(op_valid),
        .sample_in(sample_in), .sample_in_valid(sample_in_valid),
        .sample_in_ready(sample_in_ready), .dma_req(dma_req),
        .sample_out(sample_out), .sample_strobe(sample_strobe),
        .rate_22k(rate_22k), .streaming(streaming), .underrun(underrun),
        .power_on(power_on)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [15:0] o);
        op = o;
        op_valid = 1'b1;
        cyc();
        op_valid = 1'b0;
        op = '0;
    endtask

    task automatic push2(input logic [31:0] a, input logic [31:0] b);
        sample_in = a;
        sample_in_valid = 1'b1;
        cyc();
        sample_in = b;
        cyc();
        sample_in_valid = 1'b0;
    endtask

    // Cycles until the next strobe; returns 9999 if none within the budget.
    task automatic wait_strobe(output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while (!sample_strobe && cnt < 2000);
        if (!sample_strobe) cnt = 9999;
    endtask

    task automatic wait_idle(output int cnt, output logic strobed);
        cnt = 0;
        strobed = 1'b0;
        do begin
            cyc();
            cnt++;
            if (sample_strobe) strobed = 1'b1;
        end while (streaming && cnt < 2000);
        if (streaming) cnt = 9999;
    endtask

    initial begin
        // Reset state
        repeat (3) cyc();
        chk("rst_streaming", {31'b0, streaming}, 32'd0);
        chk("rst_sample_out", sample_out, 32'd0);
        chk("rst_ready", {31'b0, sample_in_ready}, 32'd0);
        chk("rst_dma_req", {31'b0, dma_req}, 32'd0);
        reset_n = 1'b1;
        cyc();

        // 44 kHz start, two-entry prefill
        cmd(16'h0f00);
        chk("t2_prime_streaming", {31'b0, streaming}, 32'd1);
        chk("t2_prime_rate", {31'b0, rate_22k}, 32'd0);
        chk("t2_prime_dma_req", {31'b0, dma_req}, 32'd1);
        chk("t2_prime_ready", {31'b0, sample_in_ready}, 32'd1);
        push2(32'h0000_000A, 32'h0000_000B);
        chk("t2_prefilled_dma_req", {31'b0, dma_req}, 32'd0);
        cyc();
        wait_strobe(n);
        chk("t2_first_interval", n, 32'd256);
        chk("t2_first_sample", sample_out, 32'h0000_000A);
        cyc();
        chk("t2_strobe_width", {31'b0, sample_strobe}, 32'd0);
        chk("t2_held_sample", sample_out, 32'h0000_000A);
        wait_strobe(n);
        chk("t2_second_interval", n, 32'd255);
        chk("t2_second_sample", sample_out, 32'h0000_000B);
        chk("t2_empty_dma_req", {31'b0, dma_req}, 32'd1);
        cmd(16'hff12);
        chk("t6_flush_stream_idle", {31'b0, streaming}, 32'd0);
        chk("t6_flush_stream_out", sample_out, 32'd0);

        // 22 kHz start, underrun on third tick
        cmd(16'h1f00);
        chk("t3_rate_22k", {31'b0, rate_22k}, 32'd1);
        push2(32'h1111_2222, 32'h3333_4444);
        cyc();
        wait_strobe(n);
        chk("t3_interval1", n, 32'd512);
        chk("t3_sample1", sample_out, 32'h1111_2222);
        wait_strobe(n);
        chk("t3_interval2", n, 32'd512);
        chk("t3_sample2", sample_out, 32'h3333_4444);
        chk("t3_no_underrun_yet", {31'b0, underrun}, 32'd0);
        wait_strobe(n);
        chk("t3_interval3", n, 32'd512);
        chk("t3_underrun_sample", sample_out, 32'd0);
        chk("t3_underrun_flag", {31'b0, underrun}, 32'd1);
        cyc();
        chk("t3_underrun_sticky", {31'b0, underrun}, 32'd1);
        cmd(16'hff00);
        chk("t6_flush_clears_underrun", {31'b0, underrun}, 32'd0);

        // Full FIFO with valid held across a tick
        cmd(16'h0f00);
        sample_in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            sample_in = 32'h100 + k;
            cyc();
        end
        chk("t4_full_ready", {31'b0, sample_in_ready}, 32'd0);
        sample_in = 32'h105;
        wait_strobe(n);
        chk("t4_first_interval", n, 32'd255);
        chk("t4_first_sample", sample_out, 32'h101);
        chk("t4_ready_after_pop", {31'b0, sample_in_ready}, 32'd1);
        cyc();
        chk("t4_refilled_ready", {31'b0, sample_in_ready}, 32'd0);
        sample_in_valid = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            wait_strobe(n);
            chk("t4_order_interval", n, (k == 2) ? 32'd255 : 32'd256);
            chk("t4_order_sample", sample_out, 32'h100 + k);
        end
        chk("t4_no_underrun", {31'b0, underrun}, 32'd0);
        cmd(16'hff00);

        // End of stream with three queued entries
        cmd(16'h0f00);
        sample_in_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            sample_in = 32'h200 + k;
            cyc();
        end
        sample_in_valid = 1'b0;
        cmd(16'hc700);
        chk("t5_c700_still_stream_ready", {31'b0, sample_in_ready}, 32'd1);
        cmd(16'hc701);
        chk("t5_drain_streaming", {31'b0, streaming}, 32'd1);
        chk("t5_drain_ready", {31'b0, sample_in_ready}, 32'd0);
        chk("t5_drain_dma_req", {31'b0, dma_req}, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            wait_strobe(n);
            chk("t5_drain_interval", n, (k == 1) ? 32'd254 : 32'd256);
            chk("t5_drain_sample", sample_out, 32'h200 + k);
        end
        wait_idle(n, seen);
        chk("t5_idle_interval", n, 32'd256);
        chk("t5_idle_no_strobe", {31'b0, seen}, 32'd0);
        chk("t5_idle_held_sample", sample_out, 32'h203);

        // Flush from PRIME and DRAIN; FIFO must restart empty
        cmd(16'h0f00);
        cmd(16'hff12);
        chk("t6_flush_prime_idle", {31'b0, streaming}, 32'd0);
        chk("t6_flush_prime_out", sample_out, 32'd0);
        cmd(16'h0f00);
        push2(32'h301, 32'h302);
        cyc();
        cmd(16'hc701);
        cmd(16'hff12);
        chk("t6_flush_drain_idle", {31'b0, streaming}, 32'd0);
        cmd(16'h0f00);
        push2(32'h311, 32'h312);
        cyc();
        wait_strobe(n);
        chk("t6_fresh_sample", sample_out, 32'h311);
        cmd(16'hff12);

        // Power-on op in IDLE
        cmd(16'hc5ef);
        chk("t6_power_on_pulse", {31'b0, power_on}, 32'd1);
        chk("t6_power_on_idle", {31'b0, streaming}, 32'd0);
        cyc();
        chk("t6_power_on_width", {31'b0, power_on}, 32'd0);

        // Asynchronous reset mid-STREAM
        cmd(16'h1f00);
        push2(32'h401, 32'h402);
        cyc();
        wait_strobe(n);
        chk("t1_pre_reset_sample", sample_out, 32'h401);
        reset_n = 1'b0;
        #2;
        chk("t1_async_streaming", {31'b0, streaming}, 32'd0);
        chk("t1_async_sample_out", sample_out, 32'd0);
        chk("t1_async_rate", {31'b0, rate_22k}, 32'd0);
        chk("t1_async_strobe", {31'b0, sample_strobe}, 32'd0);
        cyc();
        reset_n = 1'b1;
        cyc();
        cmd(16'h0f00);
        sample_in = 32'h501;
        sample_in_valid = 1'b1;
        cyc();
        sample_in_valid = 1'b0;
        chk("t1_fifo_empty_after_reset", {31'b0, dma_req}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
